// File: rtl/rename_port_arbiter_pkg.sv
// Shared widths, requester indices and FSM encodings for the rename-port arbiter.
package rename_arb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int ROB_TAG_W = 4;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LSB    = 1;
    localparam int REQ_SIMPLE = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

endpackage

// File: rtl/rename_port_arbiter_rr_picker.sv
// Combinational round-robin selector: first set bit of mask at or after ptr, wrapping.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && mask[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rename_port_arbiter.sv
// Shares the register file's single rename/operand-lookup port among N_REQ issue requesters.
// state | meaning
// IDLE  | arbitrate among pending requests (excluding the one just completed)
// ISSUE | rename_need high for exactly this cycle
// WAIT  | wait for matching rename_finish / simple_ins_commit or timeout
module rename_port_arbiter
    import rename_arb_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        register_flush,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_is_simple,
    input  logic [N_REQ-1:0]            req_is_branch_or_store,
    input  logic [N_REQ-1:0]            req_op1_flag,
    input  logic [N_REQ-1:0]            req_op2_flag,
    input  logic [REG_IDX_W*N_REQ-1:0]  req_op1_reg,
    input  logic [REG_IDX_W*N_REQ-1:0]  req_op2_reg,
    input  logic [REG_IDX_W*N_REQ-1:0]  req_rd,
    input  logic [ROB_TAG_W*N_REQ-1:0]  req_rd_rename,
    input  logic [ROB_TAG_W*N_REQ-1:0]  req_id,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            done,
    output logic                        rename_timeout,
    output logic                        rename_need,
    output logic                        rename_need_ins_is_simple,
    output logic                        rename_need_ins_is_branch_or_store,
    output logic [ROB_TAG_W-1:0]        rename_need_id,
    output logic                        operand_1_flag,
    output logic                        operand_2_flag,
    output logic [REG_IDX_W-1:0]        operand_1_reg,
    output logic [REG_IDX_W-1:0]        operand_2_reg,
    output logic [REG_IDX_W-1:0]        new_ins_rd,
    output logic [ROB_TAG_W-1:0]        new_ins_rd_rename,
    input  logic                        rename_finish,
    input  logic                        simple_ins_commit,
    input  logic [ROB_TAG_W-1:0]        rename_finish_id,
    input  logic [ROB_TAG_W-1:0]        simple_ins_rename
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] done_q;
    logic             timeout_q;

    logic [N_REQ-1:0] pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic [PTR_W-1:0] nxt_ptr;
    logic             resp_match;

    logic                 pay_simple, pay_bos, pay_f1, pay_f2;
    logic [REG_IDX_W-1:0] pay_r1, pay_r2, pay_rd;
    logic [ROB_TAG_W-1:0] pay_rdr, pay_id;

    // The requester being told done this cycle must not be re-picked off its stale req.
    rr_picker #(.N(N_REQ), .IW(PTR_W)) u_rr_picker (
        .mask   (req & ~done_q),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        pay_simple = 1'b0;
        pay_bos    = 1'b0;
        pay_f1     = 1'b0;
        pay_f2     = 1'b0;
        pay_r1     = '0;
        pay_r2     = '0;
        pay_rd     = '0;
        pay_rdr    = '0;
        pay_id     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                pay_simple = req_is_simple[i];
                pay_bos    = req_is_branch_or_store[i];
                pay_f1     = req_op1_flag[i];
                pay_f2     = req_op2_flag[i];
                pay_r1     = req_op1_reg[i*REG_IDX_W +: REG_IDX_W];
                pay_r2     = req_op2_reg[i*REG_IDX_W +: REG_IDX_W];
                pay_rd     = req_rd[i*REG_IDX_W +: REG_IDX_W];
                pay_rdr    = req_rd_rename[i*ROB_TAG_W +: ROB_TAG_W];
                pay_id     = req_id[i*ROB_TAG_W +: ROB_TAG_W];
            end
        end
    end

    assign resp_match = rename_need_ins_is_simple
                      ? (simple_ins_commit && (simple_ins_rename == new_ins_rd_rename))
                      : (rename_finish && (rename_finish_id == rename_need_id));

    assign nxt_ptr = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

    assign done           = done_q & {N_REQ{rdy}};
    assign rename_timeout = timeout_q & rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                            <= IDLE;
            ptr_q                              <= '0;
            win_q                              <= '0;
            cnt_q                              <= '0;
            done_q                             <= '0;
            timeout_q                          <= 1'b0;
            grant                              <= '0;
            rename_need                        <= 1'b0;
            rename_need_ins_is_simple          <= 1'b0;
            rename_need_ins_is_branch_or_store <= 1'b0;
            rename_need_id                     <= '0;
            operand_1_flag                     <= 1'b0;
            operand_2_flag                     <= 1'b0;
            operand_1_reg                      <= '0;
            operand_2_reg                      <= '0;
            new_ins_rd                         <= '0;
            new_ins_rd_rename                  <= '0;
        end else if (rdy) begin
            done_q    <= '0;
            timeout_q <= 1'b0;
            if (register_flush) begin
                state_q     <= IDLE;
                rename_need <= 1'b0;
                grant       <= '0;
                cnt_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pick_any) begin
                            state_q                            <= ISSUE;
                            win_q                              <= pick_idx;
                            grant                              <= pick_oh;
                            rename_need                        <= 1'b1;
                            rename_need_ins_is_simple          <= pay_simple;
                            rename_need_ins_is_branch_or_store <= pay_bos;
                            rename_need_id                     <= pay_id;
                            operand_1_flag                     <= pay_f1;
                            operand_2_flag                     <= pay_f2;
                            operand_1_reg                      <= pay_r1;
                            operand_2_reg                      <= pay_r2;
                            new_ins_rd                         <= pay_rd;
                            new_ins_rd_rename                  <= pay_rdr;
                        end else begin
                            grant <= '0;
                        end
                    end
                    ISSUE: begin
                        rename_need <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= WAIT;
                    end
                    WAIT: begin
                        if (resp_match) begin
                            done_q  <= grant;
                            ptr_q   <= nxt_ptr;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                                timeout_q <= 1'b1;
                                grant     <= '0;
                                ptr_q     <= nxt_ptr;
                                state_q   <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rename_port_arbiter.sv
// Directed bench for rename_port_arbiter; expected completions go through a scoreboard queue.
module tb_rename_port_arbiter;
    import rename_arb_pkg::*;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst, rdy, register_flush;
    logic [N-1:0] req, req_is_simple, req_is_branch_or_store, req_op1_flag, req_op2_flag;
    logic [5*N-1:0] req_op1_reg, req_op2_reg, req_rd;
    logic [4*N-1:0] req_rd_rename, req_id;
    logic [N-1:0] grant, done;
    logic         rename_timeout, rename_need, rename_need_ins_is_simple, rename_need_ins_is_branch_or_store;
    logic [3:0]   rename_need_id, new_ins_rd_rename;
    logic         operand_1_flag, operand_2_flag;
    logic [4:0]   operand_1_reg, operand_2_reg, new_ins_rd;
    logic         rename_finish, simple_ins_commit;
    logic [3:0]   rename_finish_id, simple_ins_rename;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    rename_port_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .register_flush(register_flush),
        .req(req), .req_is_simple(req_is_simple), .req_is_branch_or_store(req_is_branch_or_store),
        .req_op1_flag(req_op1_flag), .req_op2_flag(req_op2_flag),
        .req_op1_reg(req_op1_reg), .req_op2_reg(req_op2_reg), .req_rd(req_rd),
        .req_rd_rename(req_rd_rename), .req_id(req_id),
        .grant(grant), .done(done), .rename_timeout(rename_timeout),
        .rename_need(rename_need), .rename_need_ins_is_simple(rename_need_ins_is_simple),
        .rename_need_ins_is_branch_or_store(rename_need_ins_is_branch_or_store),
        .rename_need_id(rename_need_id), .operand_1_flag(operand_1_flag), .operand_2_flag(operand_2_flag),
        .operand_1_reg(operand_1_reg), .operand_2_reg(operand_2_reg), .new_ins_rd(new_ins_rd),
        .new_ins_rd_rename(new_ins_rd_rename), .rename_finish(rename_finish),
        .simple_ins_commit(simple_ins_commit), .rename_finish_id(rename_finish_id),
        .simple_ins_rename(simple_ins_rename)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_done_sb(input string tag);
        int e;
        chk({tag, "_sb_entry"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, 32'(done), 32'(1) << e);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic simple, input logic bos, input logic f1, input logic f2,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [3:0] rdr, input logic [3:0] id);
        req[i]                   = 1'b1;
        req_is_simple[i]         = simple;
        req_is_branch_or_store[i] = bos;
        req_op1_flag[i]          = f1;
        req_op2_flag[i]          = f2;
        req_op1_reg[i*5 +: 5]    = r1;
        req_op2_reg[i*5 +: 5]    = r2;
        req_rd[i*5 +: 5]         = rd;
        req_rd_rename[i*4 +: 4]  = rdr;
        req_id[i*4 +: 4]         = id;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_need"}, 32'(rename_need), 0);
        chk({tag, "_timeout"}, 32'(rename_timeout), 0);
        chk({tag, "_payload"}, {operand_1_reg, operand_2_reg, new_ins_rd, new_ins_rd_rename, rename_need_id,
                                operand_1_flag, operand_2_flag, rename_need_ins_is_simple,
                                rename_need_ins_is_branch_or_store}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; rdy = 1'b1; register_flush = 1'b0;
        req = '0; req_is_simple = '0; req_is_branch_or_store = '0; req_op1_flag = '0; req_op2_flag = '0;
        req_op1_reg = '0; req_op2_reg = '0; req_rd = '0; req_rd_rename = '0; req_id = '0;
        rename_finish = 1'b0; simple_ins_commit = 1'b0; rename_finish_id = '0; simple_ins_rename = '0;
        repeat (2) step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk("idle_grant", 32'(grant), 0);

        // ALU request: issue, response, done, then done-cycle exclusion
        set_req(REQ_ALU, 0, 0, 1, 1, 5'd5, 5'd6, 5'd7, 4'd3, 4'd2);
        step();
        chk("t1_need", 32'(rename_need), 1);
        chk("t1_grant", 32'(grant), 3'b001);
        chk("t1_fields", {operand_1_reg, operand_2_reg, new_ins_rd, new_ins_rd_rename, rename_need_id},
            {5'd5, 5'd6, 5'd7, 4'd3, 4'd2});
        chk("t1_flags", {operand_1_flag, operand_2_flag, rename_need_ins_is_simple}, 3'b110);
        step();
        chk("t1_need_low", 32'(rename_need), 0);
        chk("t1_grant_wait", 32'(grant), 3'b001);
        rename_finish = 1'b1; rename_finish_id = 4'd2; exp_q.push_back(REQ_ALU);
        step();
        rename_finish = 1'b0;
        chk_done_sb("t1_done");
        chk("t1_grant_done", 32'(grant), 3'b001);
        step();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_grant_clear", 32'(grant), 0);
        chk("t1_payload_hold", 32'(operand_1_reg), 5);
        req[REQ_ALU] = 1'b0;
        step();
        chk("t1_idle", 32'(grant), 0);

        // simple path: rename_finish with the tag must not complete it
        set_req(REQ_SIMPLE, 1, 0, 0, 0, 5'd0, 5'd0, 5'd1, 4'd9, 4'd5);
        step();
        chk("t2_grant", 32'(grant), 3'b100);
        chk("t2_simple", 32'(rename_need_ins_is_simple), 1);
        chk("t2_fields", {new_ins_rd, new_ins_rd_rename}, {5'd1, 4'd9});
        step();
        rename_finish = 1'b1; rename_finish_id = 4'd9;
        step();
        rename_finish = 1'b0;
        chk("t2_wrong_kind", 32'(done), 0);
        chk("t2_grant_wait", 32'(grant), 3'b100);
        simple_ins_commit = 1'b1; simple_ins_rename = 4'd9; exp_q.push_back(REQ_SIMPLE);
        step();
        simple_ins_commit = 1'b0;
        chk_done_sb("t2_done");
        req[REQ_SIMPLE] = 1'b0;
        step();

        // all three held: round-robin 0,1,2,0
        set_req(REQ_ALU,    0, 0, 1, 0, 5'd1, 5'd0, 5'd2, 4'd4, 4'd4);
        set_req(REQ_LSB,    0, 0, 1, 0, 5'd1, 5'd0, 5'd3, 4'd5, 4'd5);
        set_req(REQ_SIMPLE, 0, 0, 1, 0, 5'd1, 5'd0, 5'd4, 4'd6, 4'd6);
        for (int k = 0; k < 4; k++) begin
            w = k % 3;
            step();
            chk("t3_grant", 32'(grant), 32'(1) << w);
            chk("t3_need", 32'(rename_need), 1);
            step();
            rename_finish = 1'b1; rename_finish_id = 4'(4 + w); exp_q.push_back(w);
            step();
            rename_finish = 1'b0;
            chk_done_sb("t3_done");
        end
        req = '0;
        step();
        chk("t3_idle", 32'(grant), 0);

        // flush in WAIT for LSB, then regrant
        set_req(REQ_LSB, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 4'd2, 4'd7);
        step();
        chk("t4_grant", 32'(grant), 3'b010);
        chk("t4_bos", 32'(rename_need_ins_is_branch_or_store), 1);
        step();
        register_flush = 1'b1;
        step();
        register_flush = 1'b0;
        chk("t4_flush_grant", 32'(grant), 0);
        chk("t4_flush_done", 32'(done), 0);
        step();
        chk("t4_regrant", 32'(grant), 3'b010);
        chk("t4_reneed", 32'(rename_need), 1);
        step();
        rename_finish = 1'b1; rename_finish_id = 4'd7; exp_q.push_back(REQ_LSB);
        step();
        rename_finish = 1'b0;
        chk_done_sb("t4_done");
        req[REQ_LSB] = 1'b0;
        step();

        // flush in IDLE blocks the grant; then rdy stall during ISSUE
        set_req(REQ_ALU, 0, 0, 1, 1, 5'd8, 5'd9, 5'd10, 4'd3, 4'd3);
        register_flush = 1'b1;
        step();
        register_flush = 1'b0;
        chk("t5_flush_nogrant", 32'(grant), 0);
        step();
        chk("t5_grant", 32'(grant), 3'b001);
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_stall_need", 32'(rename_need), 1);
            chk("t5_stall_grant", 32'(grant), 3'b001);
            rename_finish = (k == 0);
            rename_finish_id = 4'd3;
        end
        rdy = 1'b1;
        rename_finish = 1'b0;
        step();
        chk("t5_need_low", 32'(rename_need), 0);
        rename_finish = 1'b1; rename_finish_id = 4'd3; exp_q.push_back(REQ_ALU);
        step();
        rename_finish = 1'b0;
        chk_done_sb("t5_done");
        rdy = 1'b0;
        #1;
        chk("t5_rdy_mask_done", 32'(done), 0);
        rdy = 1'b1;
        req[REQ_ALU] = 1'b0;
        step();
        chk("t5_after", 32'(done), 0);

        // no response: timeout after 15 WAIT cycles, then async reset mid-WAIT
        set_req(REQ_LSB, 0, 0, 1, 1, 5'd10, 5'd11, 5'd12, 4'd13, 4'd8);
        step();
        chk("t6_grant", 32'(grant), 3'b010);
        for (int c = 2; c <= 16; c++) begin
            step();
            rename_finish = (c == 5);
            rename_finish_id = 4'd1;
            chk("t6_no_timeout", 32'(rename_timeout), 0);
            chk("t6_grant_wait", 32'(grant), 3'b010);
        end
        rename_finish = 1'b0;
        step();
        chk("t6_timeout", 32'(rename_timeout), 1);
        chk("t6_grant_clear", 32'(grant), 0);
        chk("t6_no_done", 32'(done), 0);
        step();
        chk("t6_timeout_pulse", 32'(rename_timeout), 0);
        chk("t6_retry", 32'(grant), 3'b010);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("t6_async_rst");
        step();
        rst = 1'b0;
        req = '0;
        step();
        chk("t6_post_rst", 32'(grant), 0);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
